f2i_unit: RTL and testbench
===========================

Name: f2i_unit

Overview:
- Multi-cycle float-to-integer converter: the decode direction of the ALU's i2f packing.
- Takes a 16-bit float and returns a 16-bit two's-complement integer, truncated toward zero. Float format: sign [15], exponent [14:7] with bias 127, mantissa [6:0] with hidden 1.
- Sits beside the ALU as a handshaked coprocessor. Uses a serial 1-bit-per-cycle shifter instead of a barrel shifter.

Parameters:
- EXP_BIAS, 127, exponent bias.
- SAT_POS, 16'h7fff, result on positive overflow.
- SAT_NEG, 16'h8000, result on negative overflow.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  unit can accept an operand; equals (state==IDLE).
- in_data  input  16  float operand.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_data  output  16  integer result.
- out_ovf  output  1  result saturated.
- out_inexact  output  1  nonzero fraction bits discarded.

Behaviour:
- Reset (async, active-high): state=IDLE; out_valid=0, out_data=0, out_ovf=0, out_inexact=0; internal acc, cnt, sign and sticky all 0. Reset mid-operation abandons the operand; no result is produced.
- Definitions: e=in_data[14:7], E=e-EXP_BIAS (signed), sig={1,in_data[6:0]}, which represents 1.m*2^7.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, latch the sign. Then classify:
  - e==0: zero. out_data=0, ovf=0, inexact=0. Next state DONE.
  - 1<=e<127 (E<0): out_data=0, inexact=1. Next state DONE.
  - E==15 with sign=1 and mantissa=0: out_data=16'h8000, ovf=0, inexact=0. Exact value -32768. Next state DONE.
  - E>=15 otherwise: out_data=SAT_POS or SAT_NEG by sign, ovf=1, inexact=0. Next state DONE.
  - 0<=E<=14: acc={8'b0,sig}, cnt=|E-7| (range 0..7), direction=left if E>7, sticky=0. Next state SHIFT.
- SHIFT:
  - When cnt!=0, shift acc one bit and decrement cnt.
    - Left shift: zero fill.
    - Right shift: OR the bit shifted out into sticky.
  - When cnt==0, register out_data=sign ? (~acc+1) : acc, out_ovf=0, out_inexact=sticky. Next state DONE.
- DONE: out_valid=1, and out_data and the flags are held stable. On out_ready, out_valid falls and the next state is IDLE.
- No same-cycle accept: a new operand is accepted at the earliest on the cycle after the handoff.
- Latency, counted from the accept edge to the first out_valid=1 edge:
  - Special cases: 1 cycle.
  - Normal path: cnt+2 cycles. Worst case is 9 cycles.
- Width rule: E=14 gives acc at most 16'h7f80 after 7 left shifts, so there is no overflow inside the normal path.
- in_data is ignored outside IDLE.
- out_ready is ignored outside DONE.

Test Plan:
- Exact, no shift: in_data=16'h4348 (200.0) -> out_data=16'h00C8, ovf=0, inexact=0, out_valid 2 cycles after accept.
- Right shift with sticky: in_data=16'h3F80 (1.0) -> out_data=16'h0001, inexact=0, latency 9. Then in_data=16'hC020 (-2.5) -> out_data=16'hFFFE, inexact=1.
- Saturation boundary: 16'h4780 (65536.0) -> 16'h7FFF, ovf=1, latency 1. 16'h4700 (32768.0) -> 16'h7FFF, ovf=1. 16'hC700 (-32768.0) -> 16'h8000, ovf=0. 16'hC780 -> 16'h8000, ovf=1.
- Underflow and zero: 16'h3F00 (0.5) -> 0, inexact=1, latency 1. 16'h0000 and 16'h8000 -> 0, inexact=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data and the flags stay stable and in_ready stays 0. Raise out_ready -> in_ready=1 on the next cycle, and a back-to-back operand is accepted then.
- Reset mid-op: assert reset while in SHIFT with 16'h3F80 -> out_valid=0 and in_ready=1 immediately (async), and no stale result appears after reset is released.

Source files
------------

// File: rtl/f2i_unit.sv
// f2i_unit: multi-cycle float-to-integer converter.
// Input float: sign [15], biased exponent [14:7], 7-bit mantissa with hidden 1.
// Output: 16-bit two's-complement integer truncated toward zero, with
// saturation (out_ovf) and discarded-fraction (out_inexact) flags.
// A serial shifter moves the significand one bit per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends combinationally on ready, and out_valid with its
// out_data/flags is held unchanged until out_ready is seen.
module f2i_unit #(
  parameter logic [7:0]  EXP_BIAS = 8'd127,
  parameter logic [15:0] SAT_POS  = 16'h7fff,
  parameter logic [15:0] SAT_NEG  = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        out_inexact,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [2:0]  r_cnt;
  logic        r_left;
  logic        r_sign;
  logic        r_sticky;
  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic        r_out_ovf;
  logic        r_out_inexact;

  logic [7:0] w_e;
  logic [6:0] w_mant;
  logic       w_sign;
  logic       w_zero;
  logic       w_under;
  logic       w_big;
  logic       w_min_neg;
  logic [3:0] w_em4;
  logic [2:0] w_cnt;

  // Operand decode. In the normal range E is 0..14, so its low four bits
  // are enough to derive the shift distance and direction.
  assign w_e       = in_data[14:7];
  assign w_mant    = in_data[6:0];
  assign w_sign    = in_data[15];
  assign w_zero    = (w_e == 8'd0);
  assign w_under   = (w_e < EXP_BIAS);
  assign w_big     = ({1'b0, w_e} >= ({1'b0, EXP_BIAS} + 9'd15));
  assign w_min_neg = ({1'b0, w_e} == ({1'b0, EXP_BIAS} + 9'd15)) && w_sign && (w_mant == 7'd0);
  assign w_em4     = w_e[3:0] - EXP_BIAS[3:0];
  // |E-7|: E in 8..14 gives E-7 = low3+1; E in 0..7 gives 7-E = ~low3.
  assign w_cnt     = w_em4[3] ? (w_em4[2:0] + 3'd1) : ~w_em4[2:0];

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_ovf     = r_out_ovf;
  assign out_inexact = r_out_inexact;
  assign dbg_state   = r_state;

  // Control FSM with datapath: classify, shift serially, then hold the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_acc         <= 16'd0;
      r_cnt         <= 3'd0;
      r_left        <= 1'b0;
      r_sign        <= 1'b0;
      r_sticky      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= 16'd0;
      r_out_ovf     <= 1'b0;
      r_out_inexact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            if (w_zero) begin
              r_out_data    <= 16'd0;
              r_out_ovf     <= 1'b0;
              r_out_inexact <= 1'b0;
              r_state       <= DONE;
            end else if (w_under) begin
              r_out_data    <= 16'd0;
              r_out_ovf     <= 1'b0;
              r_out_inexact <= 1'b1;
              r_state       <= DONE;
            end else if (w_min_neg) begin
              // -32768 is representable exactly, so it is not an overflow.
              r_out_data    <= 16'h8000;
              r_out_ovf     <= 1'b0;
              r_out_inexact <= 1'b0;
              r_state       <= DONE;
            end else if (w_big) begin
              r_out_data    <= w_sign ? SAT_NEG : SAT_POS;
              r_out_ovf     <= 1'b1;
              r_out_inexact <= 1'b0;
              r_state       <= DONE;
            end else begin
              r_acc    <= {8'd0, 1'b1, w_mant};
              r_cnt    <= w_cnt;
              r_left   <= w_em4[3];
              r_sticky <= 1'b0;
              r_state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (r_cnt != 3'd0) begin
            if (r_left) begin
              r_acc <= {r_acc[14:0], 1'b0};
            end else begin
              r_acc    <= {1'b0, r_acc[15:1]};
              r_sticky <= r_sticky | r_acc[0];
            end
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_out_data    <= r_sign ? (~r_acc + 16'd1) : r_acc;
            r_out_ovf     <= 1'b0;
            r_out_inexact <= r_sticky;
            r_state       <= DONE;
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE, then waits for out_ready.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f2i_unit.sv
// Directed testbench for f2i_unit: hand-computed vectors, latency checks,
// backpressure, back-to-back acceptance and asynchronous reset mid-operation.
module tb_f2i_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_inexact;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  f2i_unit dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one operand; returns once it is accepted (or times out).
  task automatic drive_op(input logic [15:0] d);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'h0;
  endtask

  // Driver: count edges from the accept edge to out_valid=1; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Driver: complete the output handshake.
  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Driver: full conversion, capturing result and latency.
  task automatic run_vec(input logic [15:0] d, output logic [15:0] q,
                         output logic ovf, output logic inx, output int lat);
    drive_op(d);
    wait_valid(lat);
    q   = out_data;
    ovf = out_ovf;
    inx = out_inexact;
    take_result();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0 ||
        out_ovf !== 1'b0 || out_inexact !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b rdy=%b d=%h o=%b i=%b expected v=0 rdy=1 d=0000 o=0 i=0",
               out_valid, in_ready, out_data, out_ovf, out_inexact);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Table-driven conversions: operand, expected data/ovf/inexact/latency.
  task automatic test_vectors(input string name, input logic [15:0] ops[],
                              input logic [15:0] exp_d[], input logic exp_o[],
                              input logic exp_i[], input int exp_l[]);
    logic [15:0] q;
    logic        ovf, inx;
    int          lat;
    for (int k = 0; k < ops.size(); k++) begin
      run_vec(ops[k], q, ovf, inx, lat);
      n_checks++;
      if (q !== exp_d[k] || ovf !== exp_o[k] || inx !== exp_i[k] || lat != exp_l[k]) begin
        n_fail++;
        $display("FAIL %s[%h]: got d=%h o=%b i=%b lat=%0d expected d=%h o=%b i=%b lat=%0d",
                 name, ops[k], q, ovf, inx, lat, exp_d[k], exp_o[k], exp_i[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_exact();
    test_vectors("exact", '{16'h4348}, '{16'h00C8}, '{1'b0}, '{1'b0}, '{2});
  endtask

  task automatic test_right_shift();
    test_vectors("right_shift", '{16'h3F80, 16'hC020},
                 '{16'h0001, 16'hFFFE}, '{1'b0, 1'b0}, '{1'b0, 1'b1}, '{9, 8});
  endtask

  task automatic test_left_shift();
    // 0x4400 = 512.0 ; 0x46FF = 32640.0 (largest normal-path value) ; 0xC6FF = -32640.0
    test_vectors("left_shift", '{16'h4400, 16'h46FF, 16'hC6FF},
                 '{16'h0200, 16'h7F80, 16'h8080}, '{1'b0, 1'b0, 1'b0},
                 '{1'b0, 1'b0, 1'b0}, '{4, 9, 9});
  endtask

  task automatic test_saturation();
    test_vectors("saturation", '{16'h4780, 16'h4700, 16'hC700, 16'hC780},
                 '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000},
                 '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b0}, '{1, 1, 1, 1});
  endtask

  task automatic test_underflow_zero();
    test_vectors("underflow_zero", '{16'h3F00, 16'h0000, 16'h8000},
                 '{16'h0000, 16'h0000, 16'h0000}, '{1'b0, 1'b0, 1'b0},
                 '{1'b1, 1'b0, 1'b0}, '{1, 1, 1});
  endtask

  // Result held under backpressure, then a back-to-back operand right after.
  task automatic test_back_to_back();
    int lat;
    drive_op(16'h4348);
    wait_valid(lat);
    n_checks++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d expected 2", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h00C8 || out_ovf !== 1'b0 ||
          out_inexact !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h o=%b i=%b rdy=%b expected v=1 d=00c8 o=0 i=0 rdy=0",
                 c, out_valid, out_data, out_ovf, out_inexact, in_ready);
      end
    end
    take_result();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    // Operand presented in the very cycle in_ready returns.
    in_valid = 1'b1;
    in_data  = 16'h3F00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL b2b_accept: got state=%0d expected 2", dbg_state);
    end
    wait_valid(lat);
    n_checks++;
    if (lat != 1 || out_data !== 16'h0000 || out_inexact !== 1'b1 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: got lat=%0d d=%h o=%b i=%b expected lat=1 d=0000 o=0 i=1",
               lat, out_data, out_ovf, out_inexact);
    end
    take_result();
  endtask

  // Asynchronous reset while shifting abandons the operand.
  task automatic test_reset_midop();
    int          lat;
    logic [15:0] q;
    logic        ovf, inx;
    bit          stale;
    drive_op(16'h3F80);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL midop_in_shift: got state=%0d expected 1", dbg_state);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_async: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    stale = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    n_checks++;
    if (stale || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_stale: got stale=%b rdy=%b expected stale=0 rdy=1", stale, in_ready);
    end
    run_vec(16'hC020, q, ovf, inx, lat);
    n_checks++;
    if (q !== 16'hFFFE || inx !== 1'b1 || ovf !== 1'b0 || lat != 8) begin
      n_fail++;
      $display("FAIL midop_recover: got d=%h o=%b i=%b lat=%0d expected d=fffe o=0 i=1 lat=8",
               q, ovf, inx, lat);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    test_reset();
    test_exact();
    test_right_shift();
    test_left_shift();
    test_saturation();
    test_underflow_zero();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
